// File: rtl/reg_window_ctrl.sv
// Register window controller: CWP/WIM state, window requests, physical row mapping.
// Optional REGWIN_TRAP_CNT_EN adds saturating overflow/underflow trap counters.
module reg_window_ctrl #(
    parameter int NWINDOWS = 8,
    parameter int REG_BITS_SIZE = 5,
    parameter int INST_SIZE = 32,
    localparam int CWP_BITS = $clog2(NWINDOWS),
    localparam int PHYS_BITS = $clog2(8 + 16 * NWINDOWS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [2:0]               op_type,
    input  logic [INST_SIZE-1:0]     op_data,
    output logic                     op_done,
    output logic                     op_trapped,
    output logic                     op_err,
    output logic                     trap_req,
    output logic [7:0]               trap_type,
    input  logic                     trap_ack,
    input  logic [REG_BITS_SIZE-1:0] rs1,
    input  logic [REG_BITS_SIZE-1:0] rs2,
    input  logic [REG_BITS_SIZE-1:0] rd,
    output logic [PHYS_BITS-1:0]     prs1,
    output logic [PHYS_BITS-1:0]     prs2,
    output logic [PHYS_BITS-1:0]     prd,
    output logic [CWP_BITS-1:0]      cwp,
    output logic [NWINDOWS-1:0]      wim
`ifdef REGWIN_TRAP_CNT_EN
    ,
    output logic [15:0]              ovf_cnt,
    output logic [15:0]              unf_cnt
`endif
);

    localparam int ROW_BITS = CWP_BITS + 4;

    typedef enum logic [1:0] {IDLE, EXEC, TRAP} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             type_q, type_d;
    logic [INST_SIZE-1:0]   data_q, data_d;
    logic [CWP_BITS-1:0]    cwp_d, dec_cwp, inc_cwp;
    logic [NWINDOWS-1:0]    wim_d;
    logic                   done_d, trapped_d, err_d, treq_d;
    logic [7:0]             ttype_d;
    logic                   ovf_inc, unf_inc;
    logic                   is_save, is_rest, is_wrcwp, is_wrwim, is_tenter, is_rett;

    // Windowed rows wrap modulo 16*NWINDOWS, a power of two, so truncation does the mod.
    function automatic logic [PHYS_BITS-1:0] phys_row(
        input logic [CWP_BITS-1:0]      w,
        input logic [REG_BITS_SIZE-1:0] r
    );
        logic [ROW_BITS-1:0] off;
        off = {w, 4'b0000} + ROW_BITS'(r - REG_BITS_SIZE'(8));
        if (r < REG_BITS_SIZE'(8))
            return PHYS_BITS'(r);
        return PHYS_BITS'(off) + PHYS_BITS'(8);
    endfunction

    assign prs1     = phys_row(cwp, rs1);
    assign prs2     = phys_row(cwp, rs2);
    assign prd      = phys_row(cwp, rd);
    assign op_ready = (state_q == IDLE);

    assign dec_cwp   = cwp - CWP_BITS'(1);
    assign inc_cwp   = cwp + CWP_BITS'(1);
    assign is_save   = (type_q == 3'b000);
    assign is_rest   = (type_q == 3'b001);
    assign is_wrcwp  = (type_q == 3'b010);
    assign is_wrwim  = (type_q == 3'b011);
    assign is_tenter = (type_q == 3'b100);
    assign is_rett   = (type_q == 3'b101);

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        data_d    = data_q;
        cwp_d     = cwp;
        wim_d     = wim;
        done_d    = 1'b0;
        trapped_d = 1'b0;
        err_d     = 1'b0;
        treq_d    = trap_req;
        ttype_d   = trap_type;
        ovf_inc   = 1'b0;
        unf_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    type_d  = op_type;
                    data_d  = op_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
                unique case (1'b1)
                    is_save: begin
                        if (wim[dec_cwp]) begin
                            done_d  = 1'b0;
                            treq_d  = 1'b1;
                            ttype_d = 8'h05;
                            ovf_inc = 1'b1;
                            state_d = TRAP;
                        end else begin
                            cwp_d = dec_cwp;
                        end
                    end
                    is_rest, is_rett: begin
                        if (wim[inc_cwp]) begin
                            done_d  = 1'b0;
                            treq_d  = 1'b1;
                            ttype_d = 8'h06;
                            unf_inc = 1'b1;
                            state_d = TRAP;
                        end else begin
                            cwp_d = inc_cwp;
                        end
                    end
                    is_tenter: cwp_d = dec_cwp;
                    is_wrcwp: begin
                        if (data_q >= INST_SIZE'(NWINDOWS))
                            err_d = 1'b1;
                        else
                            cwp_d = data_q[CWP_BITS-1:0];
                    end
                    is_wrwim: wim_d = data_q[NWINDOWS-1:0];
                    default: err_d = 1'b1;
                endcase
            end
            TRAP: begin
                if (trap_ack) begin
                    treq_d    = 1'b0;
                    done_d    = 1'b1;
                    trapped_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            type_q     <= 3'b000;
            data_q     <= '0;
            cwp        <= '0;
            wim        <= NWINDOWS'(2);
            op_done    <= 1'b0;
            op_trapped <= 1'b0;
            op_err     <= 1'b0;
            trap_req   <= 1'b0;
            trap_type  <= 8'h00;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            data_q     <= data_d;
            cwp        <= cwp_d;
            wim        <= wim_d;
            op_done    <= done_d;
            op_trapped <= trapped_d;
            op_err     <= err_d;
            trap_req   <= treq_d;
            trap_type  <= ttype_d;
        end
    end

`ifdef REGWIN_TRAP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt <= 16'h0000;
            unf_cnt <= 16'h0000;
        end else begin
            if (ovf_inc && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'h0001;
            if (unf_inc && unf_cnt != 16'hFFFF)
                unf_cnt <= unf_cnt + 16'h0001;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ovf_inc ^ unf_inc;
`endif

endmodule

// File: doc/reg_window_ctrl.md
# reg_window_ctrl

Register window controller for the integer register file. Owns the current window pointer (CWP) and window invalid mask (WIM), and translates 5-bit architectural register numbers into physical register-file row addresses. Executes SAVE/RESTORE/trap-entry/RETT/WRCWP/WRWIM requests from decode through a valid/ready handshake. Raises window overflow/underflow trap requests toward the trap unit. Sits between decode and the register file read/write address ports.

## Interface
- NWINDOWS, 8: number of register windows; power of two, 2..32.
- REG_BITS_SIZE, 5: architectural register number width.
- INST_SIZE, 32: width of `op_data`.
- Derived localparams: CWP_BITS = $clog2(NWINDOWS); PHYS_BITS = $clog2(8 + 16*NWINDOWS).

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  controller can accept a request.
- op_type  in  3  request type: 000 SAVE, 001 RESTORE, 010 WRCWP, 011 WRWIM, 100 TRAP_ENTER, 101 RETT, others illegal.
- op_data  in  INST_SIZE  operand for WRCWP/WRWIM.
- op_done  out  1  one-cycle completion pulse.
- op_trapped  out  1  qualifies `op_done`: request trapped; CWP is unchanged.
- op_err  out  1  qualifies `op_done`: illegal `op_type`, or WRCWP value ≥ NWINDOWS; no state change.
- trap_req  out  1  window trap pending.
- trap_type  out  8  0x05 overflow, 0x06 underflow; valid while `trap_req`.
- trap_ack  in  1  trap unit has taken the trap.
- rs1, rs2, rd  in  REG_BITS_SIZE each  architectural register numbers.
- prs1, prs2, prd  out  PHYS_BITS each  physical row addresses.
- cwp  out  CWP_BITS  current window pointer.
- wim  out  NWINDOWS  window invalid mask.

## Operation
**Address map (combinational from current `cwp`):**
- r0–r7 map to physical row r.
- r8–r31 map to `8 + ((16*cwp + r - 8) mod 16*NWINDOWS)`.
- Consequence: caller outs equal callee ins after SAVE.

**FSM states:** IDLE, EXEC, TRAP.
- IDLE: `op_ready`=1. On `op_valid && op_ready`, capture `op_type`/`op_data` and go to EXEC.
- EXEC: `op_ready`=0. Compute `new_cwp`:
  - SAVE and TRAP_ENTER: `cwp-1 mod NWINDOWS`.
  - RESTORE and RETT: `cwp+1 mod NWINDOWS`.
- EXEC, SAVE/RESTORE/RETT with `wim[new_cwp]`=1: CWP is not updated. Load `trap_type` (SAVE gives 0x05; RESTORE/RETT give 0x06) and go to TRAP.
- EXEC, otherwise:
  - SAVE/RESTORE/RETT/TRAP_ENTER: update CWP (TRAP_ENTER never checks WIM).
  - WRCWP: `cwp` = `op_data[CWP_BITS-1:0]`; error if `op_data` ≥ NWINDOWS.
  - WRWIM: `wim` = `op_data[NWINDOWS-1:0]`; upper bits are ignored.
  - Pulse `op_done` and go to IDLE.
- TRAP: `trap_req`=1. When `trap_ack`=1 is sampled, pulse `op_done` with `op_trapped`=1 and go to IDLE.
- `trap_ack` outside TRAP is ignored.

## Timing
- All outputs except `op_ready`, `prs1`, `prs2`, `prd` are registered.
- Reset values: state IDLE, `cwp`=0, `wim`=0x2 (bit 1 only), `op_done`/`op_trapped`/`op_err`/`trap_req`=0, `trap_type`=0x00. `op_ready`=1 after reset.
- Accept at edge N. The EXEC decision is registered at edge N+1: new `cwp`/`wim` and `op_done` are visible in cycle N+1..N+2. `op_ready` returns high in cycle N+1, so throughput is one request per 2 cycles.
- Trap path: `trap_req` rises after edge N+1 and holds until the edge that samples `trap_ack`=1. `trap_req` falls and `op_done` pulses in that same following cycle.
- `p*` outputs follow the updated `cwp` in the same cycle it changes. Decode must not issue reads in the cycle `op_done` is low while busy.
- `op_valid` while not ready is not accepted; the requester holds it.
- Reset asserted mid-request (EXEC or TRAP): immediate return to reset values. `trap_req` drops asynchronously and the request is lost.
- CWP wraps at both ends (0−1 gives NWINDOWS−1; NWINDOWS−1+1 gives 0).

## Configuration
- `REGWIN_TRAP_CNT_EN` defined:
  - Adds outputs `ovf_cnt` and `unf_cnt` (16 bits each).
  - They count overflow and underflow traps, incremented on entry to TRAP.
  - They saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then `rs1`=8, `rs2`=24, `rd`=3 → `cwp`=0, `wim`=0x02, `prs1`=8, `prs2`=24, `prd`=3.
- SAVE from reset (NWINDOWS=8) → after 2 cycles `cwp`=7, `op_done`=1, `op_trapped`=0. `rs1`=24 gives `prs1`=8 + ((112+16) mod 128) = 8, equal to the caller's r8.
- RESTORE from reset → `wim[1]`=1, so `trap_req`=1 with `trap_type`=0x06 and `cwp` stays 0. Hold `trap_ack` low 3 cycles then high 1 → `op_done`+`op_trapped` pulse, `op_ready` returns high.
- WRWIM `op_data`=0xFFFF_FF80, then TRAP_ENTER from `cwp`=0 → `wim`=0x80, then `cwp`=7 with no trap. A following SAVE from 7 goes to 6, no trap.
- WRCWP `op_data`=9 → `op_done` with `op_err`=1 and `cwp` unchanged. `op_type`=111 → `op_err`=1.
- Assert reset while in TRAP → `trap_req` low immediately and all reset values restored. With `REGWIN_TRAP_CNT_EN`, two SAVE overflows give `ovf_cnt`=2.
